// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg
// Shared types and defaults for the transmit frame scheduler.
//   sched_state_t      : scheduler FSM states
//   DEF_* localparams  : default slot count, inter-frame gap and watchdog limit
package tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_STREAM,
        ST_GAP
    } sched_state_t;

    localparam int DEF_N_SLOTS        = 4;
    localparam int DEF_IFG_CYCLES     = 12;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: returns the first set bit of req
// searching upward from last+1, wrapping N-1 -> 0. The last-granted slot
// itself is checked last, so it only wins again when nobody else asks.
//   req   in  N       : request vector
//   last  in  log2(N) : previously granted index
//   grant out log2(N) : chosen index (0 when valid is low)
//   valid out 1       : at least one request present
module rr_arbiter
    import tx_sched_pkg::*;
#(
    parameter int N = DEF_N_SLOTS
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest set
    // bit is the final (winning) assignment.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(last) + k) % N);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched
// Shares one MAC transmit byte stream between N_SLOTS slot engines.
// Picks the next loaded slot round-robin, pulses its start, forwards MAC
// backpressure to it while streaming, muxes its bytes onto the MAC one
// cycle late, enforces an inter-frame gap and aborts a stuck slot.
//   clk, clr_n         : clock, synchronous active-low reset
//   req                : per-slot frame-ready levels
//   slot_start/clr     : one-cycle start / abort pulses (clr all ones in reset)
//   slot_data_av       : MAC ready forwarded to the streaming slot only
//   slot_busy/fin      : per-slot busy level and end-of-frame pulse
//   slot_data_en/out   : per-slot byte stream (slot i at [8i+7:8i])
//   mac_data_av/en/out : MAC transmit interface
//   done, timeout_err  : normal-finish and watchdog-abort pulses
//   active, cur_slot   : not idle; current or last granted slot
module tx_frame_sched
    import tx_sched_pkg::*;
#(
    parameter int N_SLOTS        = DEF_N_SLOTS,
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [N_SLOTS-1:0]         req,
    output logic [N_SLOTS-1:0]         slot_start,
    output logic [N_SLOTS-1:0]         slot_clr,
    output logic [N_SLOTS-1:0]         slot_data_av,
    input  logic [N_SLOTS-1:0]         slot_busy,
    input  logic [N_SLOTS-1:0]         slot_data_en,
    input  logic [8*N_SLOTS-1:0]       slot_data_out,
    input  logic [N_SLOTS-1:0]         slot_fin,
    input  logic                       mac_data_av,
    output logic                       mac_data_en,
    output logic [7:0]                 mac_data_out,
    output logic [N_SLOTS-1:0]         done,
    output logic                       timeout_err,
    output logic                       active,
    output logic [$clog2(N_SLOTS)-1:0] cur_slot
);

    localparam int SW  = $clog2(N_SLOTS);
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW  = $clog2(IFG_CYCLES) + 1;

    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(IFG_CYCLES);
    localparam logic [SW-1:0]  LAST_RST = SW'(N_SLOTS - 1);

    sched_state_t   state_q, state_d;
    logic [SW-1:0]  cur_q, cur_d;
    logic [SW-1:0]  last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           mac_en_q, mac_en_d;
    logic [7:0]     mac_data_q, mac_data_d;

    logic [SW-1:0]      arb_grant;
    logic               arb_valid;
    logic [N_SLOTS-1:0] cur_onehot;
    logic               start_p, done_p, abort_p, av_fwd, mux_on;
    logic               wd_expired;

    rr_arbiter #(.N(N_SLOTS)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign cur_onehot = {{(N_SLOTS-1){1'b0}}, 1'b1} << cur_q;
    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        wd_d       = wd_q;
        gap_d      = gap_q;
        start_p    = 1'b0;
        done_p     = 1'b0;
        abort_p    = 1'b0;
        av_fwd     = 1'b0;
        mux_on     = 1'b0;
        mac_en_d   = 1'b0;
        mac_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    cur_d   = arb_grant;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                start_p = 1'b1;
                wd_d    = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                wd_d = wd_q + 1'b1;
                if (wd_expired) begin
                    abort_p = 1'b1;
                end else if (slot_busy[cur_q]) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                av_fwd = 1'b1;
                mux_on = 1'b1;
                wd_d   = wd_q + 1'b1;
                // fin beats a watchdog expiry landing on the same cycle
                if (slot_fin[cur_q]) begin
                    done_p  = 1'b1;
                    last_d  = cur_q;
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else if (wd_expired) begin
                    abort_p = 1'b1;
                end
            end
            ST_GAP: begin
                // keep the mux open so trailing CRC bytes still reach the MAC
                mux_on = 1'b1;
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_p) begin
            last_d  = cur_q;
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
        end

        if (mux_on) begin
            mac_en_d   = slot_data_en[cur_q];
            mac_data_d = slot_data_out[8*cur_q +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            last_q     <= LAST_RST;
            wd_q       <= '0;
            gap_q      <= '0;
            mac_en_q   <= 1'b0;
            mac_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
            mac_en_q   <= mac_en_d;
            mac_data_q <= mac_data_d;
        end
    end

    // Pulses are suppressed while reset is held so no slot sees a stray
    // start/done during the reset cycle; slot_clr instead goes all ones.
    assign slot_start   = (clr_n && start_p) ? cur_onehot : '0;
    assign done         = (clr_n && done_p) ? cur_onehot : '0;
    assign slot_data_av = (clr_n && av_fwd && mac_data_av) ? cur_onehot : '0;
    assign slot_clr     = !clr_n ? '1 : (abort_p ? cur_onehot : '0);
    assign timeout_err  = clr_n && abort_p;
    assign active       = (state_q != ST_IDLE);
    assign cur_slot     = cur_q;
    assign mac_data_en  = mac_en_q;
    assign mac_data_out = mac_data_q;

endmodule

// File: doc/tx_frame_sched.md
# tx_frame_sched

Round-robin scheduler that shares one MAC transmit byte stream between `N_SLOTS` TCP transmit slot engines. It decides which loaded slot transmits next, pulses that slot's `start`, forwards the MAC `data_av` backpressure to it, and muxes its byte stream onto the MAC. It also enforces an inter-frame gap and recovers a stuck slot with a watchdog. It sits between the per-connection transmit slots and the Ethernet MAC transmit interface.

## Interface
- `N_SLOTS`, 4: number of slot engines (2–8).
- `IFG_CYCLES`, 12: idle cycles enforced after each frame end.
- `TIMEOUT_CYCLES`, 4096: maximum cycles from start pulse to `fin` before the slot is aborted.
- `clk` in 1: single clock, all logic on rising edge.
- `clr_n` in 1: reset, synchronous, active-low.
- `req` in N_SLOTS: slot has a frame loaded and wants to send (level).
- `slot_start` out N_SLOTS: one-cycle start pulse to the granted slot.
- `slot_clr` out N_SLOTS: one-cycle clear to a slot (timeout); all ones while `clr_n`=0.
- `slot_data_av` out N_SLOTS: MAC ready, forwarded to the granted slot only.
- `slot_busy` in N_SLOTS: slot busy flags.
- `slot_data_en` in N_SLOTS: slot byte valid.
- `slot_data_out` in 8*N_SLOTS: slot bytes, slot i at [8i+7:8i].
- `slot_fin` in N_SLOTS: slot end-of-frame pulse.
- `mac_data_av` in 1: MAC can accept bytes.
- `mac_data_en` out 1: byte valid to MAC.
- `mac_data_out` out 8: byte to MAC.
- `done` out N_SLOTS: one-cycle pulse when slot i finished normally.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.
- `active` out 1: high in any state other than IDLE.
- `cur_slot` out $clog2(N_SLOTS): currently or last granted slot.

## Operation
- States: IDLE, START, WAIT_BUSY, STREAM, GAP.
- IDLE:
  - If any `req` bit is set, grant the first set bit searching from `last+1` mod N_SLOTS upward.
  - Latch the grant into `cur_slot`, go to START.
- START:
  - `slot_start[cur_slot]`=1 for exactly this cycle.
  - Clear the watchdog counter, go to WAIT_BUSY.
- WAIT_BUSY: on `slot_busy[cur_slot]`=1, go to STREAM.
- STREAM:
  - `slot_data_av[cur_slot]` = `mac_data_av` (combinational); all other `slot_data_av` bits are 0.
  - On `slot_fin[cur_slot]`: pulse `done[cur_slot]`, set `last`=`cur_slot`, load the gap counter with IFG_CYCLES, go to GAP.
- GAP:
  - Count down to 0, then go to IDLE.
  - `slot_data_av` is all 0.
- Watchdog:
  - Increments every cycle in WAIT_BUSY and STREAM.
  - When it equals TIMEOUT_CYCLES-1 and no `fin` arrives that cycle: pulse `slot_clr[cur_slot]` and `timeout_err`, set `last`=`cur_slot`, go to GAP. No `done` pulse.
- Byte mux:
  - `mac_data_en`/`mac_data_out` are registered copies of `slot_data_en[cur_slot]`/`slot_data_out[cur_slot]`.
  - The mux is active in STREAM and GAP, so trailing CRC bytes after `fin` pass through. It is forced to 0 in IDLE, START and WAIT_BUSY.
- `req` is sampled only in IDLE. Requests arriving in other states wait; they are never lost while held.
- `fin` or `data_en` from non-granted slots is ignored.

## Timing
- Reset values:
  - All outputs 0, except `slot_clr`, which is all ones while `clr_n`=0.
  - State IDLE, `last`=N_SLOTS-1 so slot 0 wins first.
  - Counters 0, `cur_slot`=0.
- Request to start: `req` high in IDLE at cycle t gives `slot_start` at t+1.
- Byte latency: a slot byte at cycle t appears on the MAC at t+1.
- Frame spacing: from `fin` to the next `slot_start` is at least IFG_CYCLES+2 cycles.
- Simultaneous `fin` and watchdog expiry: `fin` wins, giving a normal `done`.
- Reset mid-frame: returns to IDLE next cycle, `mac_data_en`=0, all slots cleared.
- Counter widths:
  - Watchdog: $clog2(TIMEOUT_CYCLES)+1 bits.
  - Gap counter: $clog2(IFG_CYCLES)+1 bits.
- Round-robin pointer wraps N_SLOTS-1 → 0.

## Structure
- Shared package `tx_sched_pkg`: state enum `sched_state_t`, default IFG/timeout constants.
- One sub-module `rr_arbiter` (req vector + last pointer → grant index + valid), purely combinational.
- Everything else lives in `tx_frame_sched`.

## Test plan
- Single request: `req`=0001 → `slot_start`=0001 one cycle later, `cur_slot`=0; 60 bytes + `fin` → 60 bytes on MAC delayed 1 cycle, `done`=0001, next start ≥14 cycles after `fin`.
- Fairness: `req`=1111 held across 8 frames → grant order 0,1,2,3,0,1,2,3.
- Backpressure: `mac_data_av` toggled 1/0 each cycle → `slot_data_av[cur]` mirrors it, non-granted bits stay 0.
- Timeout with TIMEOUT_CYCLES=64: slot never raises `busy` → at cycle 64 after start, `slot_clr`=0001 and `timeout_err` pulse; after 12 gap cycles, slot 1 (`req`=0011) is granted.
- Race: `fin` on the exact watchdog-expiry cycle → `done` pulse, no `timeout_err`, no `slot_clr`.
- Reset mid-STREAM: `clr_n`=0 for 1 cycle → `slot_clr`=1111, `mac_data_en`=0 next cycle, IDLE, first grant after reset goes to slot 0.
